// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer controller and its prescaler.
package timer_pkg;

  // State encoding, also visible on the controller's state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_FINISH = 2'b11
  } timer_state_t;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int safe_width(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled, wraps on the last value.
// tick reports "prescaler sits on its last value"; the owner decides whether
// that cycle actually consumes a tick.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            PW   = safe_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;

  assign tick = (pre_q == LAST);

  // Phase counter: cleared on load/abort, frozen while en is low.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: IDLE/RUN/PAUSE/FINISH FSM with count register,
// pause/resume with preserved tick phase, clear, auto-reload and a bounded
// alarm. All outputs are registered; load/run decode the next state so they
// line up with the state output.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int TICK_DIV     = 1000,
  parameter int ALARM_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] load_val,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] count,
  output logic             load,
  output logic             run,
  output logic             done,
  output logic             alarm
);

  localparam int            AW         = safe_width(ALARM_CYCLES);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    alarm_cnt_q, alarm_cnt_d;
  logic             alarm_q, alarm_d;
  logic             done_q, done_d;
  logic             load_q, load_d;
  logic             run_q, run_d;

  logic pre_last;
  logic run_tick;
  logic idle_load;
  logic reload;
  logic pre_clr;
  logic pre_en;

  // A tick only counts while running; a zero load value never starts or reloads.
  assign run_tick  = (state_q == ST_RUN) && pre_last;
  assign idle_load = (state_q == ST_IDLE) && start && (load_val != '0);
  assign reload    = run_tick && (count_q == CNT_W'(1)) && auto_reload && (load_val != '0);
  assign pre_clr   = clear || idle_load || reload;
  // Pause freezes the phase, except that a due tick is still consumed.
  assign pre_en    = (state_q == ST_RUN) && (!pause || pre_last);

  timer_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (pre_last)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      alarm_d     = 1'b0;
      alarm_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (idle_load) begin
            state_d = ST_RUN;
            count_d = load_val;
          end
        end
        ST_RUN: begin
          if (run_tick) begin
            if (count_q == CNT_W'(1)) begin
              done_d = 1'b1;
              if (reload) begin
                count_d = load_val;
                state_d = pause ? ST_PAUSE : ST_RUN;
              end else begin
                count_d     = '0;
                state_d     = ST_FINISH;
                alarm_d     = 1'b1;
                alarm_cnt_d = ALARM_LAST;
              end
            end else begin
              count_d = count_q - CNT_W'(1);
              state_d = pause ? ST_PAUSE : ST_RUN;
            end
          end else if (pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        ST_FINISH: begin
          if (start) begin
            state_d     = ST_IDLE;
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
          end else if (alarm_cnt_q != '0) begin
            alarm_cnt_d = alarm_cnt_q - AW'(1);
          end else begin
            alarm_d = 1'b0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          count_d     = '0;
          alarm_d     = 1'b0;
          alarm_cnt_d = '0;
        end
      endcase
    end

    load_d = (state_d == ST_IDLE);
    run_d  = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      alarm_cnt_q <= '0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b1;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      alarm_cnt_q <= alarm_cnt_d;
      alarm_q     <= alarm_d;
      done_q      <= done_d;
      load_q      <= load_d;
      run_q       <= run_d;
    end
  end

  assign state = state_q;
  assign count = count_q;
  assign load  = load_q;
  assign run   = run_q;
  assign done  = done_q;
  assign alarm = alarm_q;

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Parametrised countdown timer controller: the next generation of the team's INPUT/COUNTDOWN/FINISH timer FSM. It owns the count register and a tick prescaler internally, and adds pause/resume, an explicit clear, auto-reload mode and a bounded alarm output. It sits between the user-input/load logic and the display/alarm drivers, and exposes the current state and count for both.

Parameters:
CNT_W, 16, width of the count register and load_val.
TICK_DIV, 1000, clk cycles per count decrement (>=1); prescaler width is $clog2(TICK_DIV) (1 minimum).
ALARM_CYCLES, 8, cycles alarm stays high after expiry (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high; highest priority.
start  in  1  level, sampled each cycle; starts the countdown in IDLE, acknowledges in FINISH.
pause  in  1  level; high holds the countdown.
clear  in  1  level; abort to IDLE from any state.
auto_reload  in  1  level; sampled at expiry.
load_val  in  CNT_W  countdown start value, sampled on the start edge.
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 FINISH.
count  out  CNT_W  current remaining count.
load  out  1  high in IDLE (input entry enabled).
run  out  1  high in RUN only.
done  out  1  one-cycle pulse on each expiry.
alarm  out  1  high for ALARM_CYCLES cycles after a non-reload expiry.

Behaviour:
- One clock; reset is synchronous and active-high. Reset -> state=IDLE, count=0, prescaler=0, load=1, run=0, done=0, alarm=0, alarm counter=0.
- Priority each cycle: reset > clear > state transitions. Clear in any state: same values as reset, on the next edge.
- All outputs are registered. load and run are decoded from the next state, so they align with state.
- IDLE: if start=1 and load_val!=0 -> RUN, count<=load_val, prescaler<=0. If start=1 and load_val==0 -> ignored, stay IDLE.
- RUN: prescaler increments every cycle. tick = (prescaler==TICK_DIV-1); on tick the prescaler wraps to 0 and count decrements.
  - pause=1 (and no tick) -> PAUSE. The prescaler is frozen, so the phase is preserved.
  - If tick and pause coincide, the tick is applied first, then the block enters PAUSE (or FINISH if it expired).
  - Expiry: a tick with count==1. If auto_reload=1: count<=load_val (resampled), stay RUN, done pulses; alarm is not raised. If load_val==0 at reload -> treat as auto_reload=0.
  - Non-reload expiry: count<=0, state<=FINISH, done=1 for one cycle, alarm=1, alarm counter<=ALARM_CYCLES-1.
- PAUSE: count and prescaler hold. When pause=0 -> RUN on the next edge, and counting resumes from the frozen prescaler value. start is ignored.
- FINISH: count=0. alarm stays high while alarm counter>0, decrementing each cycle, and drops after exactly ALARM_CYCLES high cycles. start=1 -> IDLE (alarm forced 0). A new countdown needs start to be seen again in IDLE, i.e. at least one later cycle.
- Timing: with start at edge E, the first decrement happens at edge E+TICK_DIV and expiry at edge E+load_val*TICK_DIV.
- Counter arithmetic is unsigned CNT_W. The count never underflows, because 0 is only reached via expiry.
- Unused state encoding: none exist with 2 bits. A default branch still forces IDLE.

Decomposition:
- Package timer_pkg holds the state encodings (IDLE, RUN, PAUSE, FINISH) as a 2-bit typedef enum, plus a clog2-safe width helper constant function.
- Sub-module timer_prescaler: parameters TICK_DIV; ports clk, reset, clr, en, tick. Here clr maps to the start/reload load and en to state==RUN. Everything else stays in countdown_timer_ctrl.

Test Plan:
1. CNT_W=8, TICK_DIV=4, ALARM_CYCLES=3; reset, load_val=3, start 1 cycle -> state=RUN next edge, count 3->2->1->0 at +4/+8/+12 cycles, done pulse 1 cycle at +12, state=FINISH, alarm high exactly 3 cycles.
2. Pause: load_val=5, assert pause 2 cycles after start for 10 cycles -> count frozen at 5 and state=PAUSE. After release, the first decrement comes 2 cycles later (phase kept) and expiry lands 10+1 cycles later than in the unpaused case.
3. Auto-reload: auto_reload=1, load_val=2 -> done pulses every 8 cycles, state stays RUN, alarm never rises. Drop auto_reload -> the next expiry goes to FINISH.
4. start with load_val=0 in IDLE -> state stays IDLE, load=1, done=0.
5. clear mid-RUN (count=4) and reset mid-PAUSE -> next edge state=IDLE, count=0, all flags 0. A simultaneous start is ignored.
6. In FINISH, pulse start during the alarm -> IDLE next edge, alarm=0 immediately, load=1.
